// File: rtl/mem_arbiter.sv
// Single-owner arbiter for the shared single-port mem: loader > data > fetch, with loader lock.
// Optional MEM_ARB_RR_EN: data and fetch alternate via last_cpu instead of data-first.
module mem_arbiter #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  ld_req,
   input  logic                  ld_lock,
   input  logic                  ld_we,
   input  logic [ADDR_WIDTH-1:0] ld_addr,
   input  logic [DATA_WIDTH-1:0] ld_wdata,
   output logic                  ld_gnt,
   output logic                  ld_rvalid,
   input  logic                  f_req,
   input  logic [ADDR_WIDTH-1:0] f_addr,
   output logic                  f_gnt,
   output logic                  f_rvalid,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic                  d_gnt,
   output logic                  d_rvalid,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  cpu_hold,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_din,
   input  logic [DATA_WIDTH-1:0] mem_dout
);

   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
   typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_LD = 2'd1, OWN_D = 2'd2, OWN_F = 2'd3} owner_t;

   state_t                state, state_n;
   owner_t                owner, owner_n;
   logic                  rd_pend, rd_pend_n;
   logic                  lock_active, lock_n;
   logic                  ld_gnt_n, f_gnt_n, d_gnt_n;
   logic                  ld_rvalid_n, f_rvalid_n, d_rvalid_n;
   logic [DATA_WIDTH-1:0] rdata_n;
   logic                  cpu_hold_n;
   logic                  mem_we_n;
   logic [ADDR_WIDTH-1:0] mem_addr_n;
   logic [DATA_WIDTH-1:0] mem_din_n;
   logic                  cpu_ok, d_sel, f_sel;

   // A held lock blocks the CPU ports, except at the arbitration point where ld_lock drops.
   assign cpu_ok = !(lock_active && ld_lock);

`ifdef MEM_ARB_RR_EN
   logic last_cpu, last_n;   // 1: data was the last CPU port served
   assign d_sel = d_req && (!f_req || !last_cpu);
`else
   assign d_sel = d_req;
`endif
   assign f_sel = f_req && !d_sel;

   // Next-state and next-output logic.
   always_comb begin
      state_n     = state;
      owner_n     = owner;
      rd_pend_n   = rd_pend;
      lock_n      = lock_active;
`ifdef MEM_ARB_RR_EN
      last_n      = last_cpu;
`endif
      ld_gnt_n    = 1'b0;
      f_gnt_n     = 1'b0;
      d_gnt_n     = 1'b0;
      ld_rvalid_n = 1'b0;
      f_rvalid_n  = 1'b0;
      d_rvalid_n  = 1'b0;
      rdata_n     = rdata;
      mem_we_n    = 1'b0;
      mem_addr_n  = mem_addr;
      mem_din_n   = mem_din;

      if (state == RESP && rd_pend) begin
         rdata_n = mem_dout;
         case (owner)
            OWN_LD:  ld_rvalid_n = 1'b1;
            OWN_D:   d_rvalid_n  = 1'b1;
            OWN_F:   f_rvalid_n  = 1'b1;
            default: ;
         endcase
      end

      unique case (state)
         ACCESS: state_n = RESP;
         IDLE, RESP: begin
            state_n   = IDLE;
            owner_n   = OWN_NONE;
            rd_pend_n = 1'b0;
            if (lock_active && !ld_lock) lock_n = 1'b0;
            if (ld_req) begin
               state_n    = ACCESS;
               owner_n    = OWN_LD;
               ld_gnt_n   = 1'b1;
               lock_n     = ld_lock;
               mem_we_n   = ld_we;
               mem_addr_n = ld_addr;
               mem_din_n  = ld_wdata;
               rd_pend_n  = !ld_we;
            end else if (cpu_ok && d_sel) begin
               state_n    = ACCESS;
               owner_n    = OWN_D;
               d_gnt_n    = 1'b1;
               mem_we_n   = d_we;
               mem_addr_n = d_addr;
               mem_din_n  = d_wdata;
               rd_pend_n  = !d_we;
`ifdef MEM_ARB_RR_EN
               last_n     = 1'b1;
`endif
            end else if (cpu_ok && f_sel) begin
               state_n    = ACCESS;
               owner_n    = OWN_F;
               f_gnt_n    = 1'b1;
               mem_addr_n = f_addr;
               rd_pend_n  = 1'b1;
`ifdef MEM_ARB_RR_EN
               last_n     = 1'b0;
`endif
            end
         end
         default: state_n = IDLE;
      endcase

      cpu_hold_n = lock_n || (state_n != IDLE && owner_n == OWN_LD);
   end

   // State and registered outputs; reset aborts any in-flight access.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         owner       <= OWN_NONE;
         rd_pend     <= 1'b0;
         lock_active <= 1'b0;
`ifdef MEM_ARB_RR_EN
         last_cpu    <= 1'b0;
`endif
         ld_gnt      <= 1'b0;
         f_gnt       <= 1'b0;
         d_gnt       <= 1'b0;
         ld_rvalid   <= 1'b0;
         f_rvalid    <= 1'b0;
         d_rvalid    <= 1'b0;
         rdata       <= '0;
         cpu_hold    <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_din     <= '0;
      end else begin
         state       <= state_n;
         owner       <= owner_n;
         rd_pend     <= rd_pend_n;
         lock_active <= lock_n;
`ifdef MEM_ARB_RR_EN
         last_cpu    <= last_n;
`endif
         ld_gnt      <= ld_gnt_n;
         f_gnt       <= f_gnt_n;
         d_gnt       <= d_gnt_n;
         ld_rvalid   <= ld_rvalid_n;
         f_rvalid    <= f_rvalid_n;
         d_rvalid    <= d_rvalid_n;
         rdata       <= rdata_n;
         cpu_hold    <= cpu_hold_n;
         mem_we      <= mem_we_n;
         mem_addr    <= mem_addr_n;
         mem_din     <= mem_din_n;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, directed corner sequences, random scoreboard.
module tb_mem_arbiter;
   localparam int unsigned AW = 16;
   localparam int unsigned DW = 8;

   logic          clk = 1'b0;
   logic          reset_n = 1'b1;
   logic          ld_req = 0, ld_lock = 0, ld_we = 0;
   logic [AW-1:0] ld_addr = '0;
   logic [DW-1:0] ld_wdata = '0;
   logic          ld_gnt, ld_rvalid;
   logic          f_req = 0;
   logic [AW-1:0] f_addr = '0;
   logic          f_gnt, f_rvalid;
   logic          d_req = 0, d_we = 0;
   logic [AW-1:0] d_addr = '0;
   logic [DW-1:0] d_wdata = '0;
   logic          d_gnt, d_rvalid;
   logic [DW-1:0] rdata;
   logic          cpu_hold, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din;
   logic [DW-1:0] mem_dout = '0;

   mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .reset_n(reset_n),
      .ld_req(ld_req), .ld_lock(ld_lock), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
      .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid),
      .rdata(rdata), .cpu_hold(cpu_hold),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
   );

   always #5 clk = ~clk;

   // Synchronous single-port memory, read-before-write.
   logic [DW-1:0] mem_arr [0:65535];
   logic [DW-1:0] ref_mem [0:65535];
   always @(posedge clk) begin
      if (mem_we) mem_arr[mem_addr] <= mem_din;
      mem_dout <= mem_arr[mem_addr];
   end

   int passed = 0;
   int total  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic          lr, ll, lw;
      logic [AW-1:0] la;
      logic [DW-1:0] lwd;
      logic          fr;
      logic [AW-1:0] fa;
      logic [2:0]    e_gnt;   // {ld, d, f}
      logic [2:0]    e_rv;    // {ld, d, f}
      logic [DW-1:0] e_rdata;
      logic          e_hold, e_we;
   } vec_t;

   function automatic vec_t mk(input logic lr, ll, lw, input logic [AW-1:0] la,
                               input logic [DW-1:0] lwd, input logic fr, input logic [AW-1:0] fa,
                               input logic [2:0] eg, er, input logic [DW-1:0] ed,
                               input logic eh, ew);
      vec_t v;
      v.lr = lr; v.ll = ll; v.lw = lw; v.la = la; v.lwd = lwd; v.fr = fr; v.fa = fa;
      v.e_gnt = eg; v.e_rv = er; v.e_rdata = ed; v.e_hold = eh; v.e_we = ew;
      return v;
   endfunction

   function automatic logic [AW-1:0] raddr();
      logic [AW-1:0] base;
      base = ($urandom_range(0, 1) != 0) ? 16'hFF00 : 16'h0100;
      return base | AW'($urandom_range(0, 15));
   endfunction

   task automatic ld_write(input logic [AW-1:0] a, input logic [DW-1:0] v);
      bit got = 0;
      ld_req = 1; ld_we = 1; ld_addr = a; ld_wdata = v; ld_lock = 0;
      for (int k = 0; k < 10 && !got; k++) begin
         tick();
         if (ld_gnt) got = 1;
      end
      ld_req = 0; ld_we = 0;
      chk("ld_write.gnt", 32'(got), 1);
      tick(); tick();
   endtask

   localparam int NV = 22;
   vec_t vt [NV];

   initial begin
      for (int i = 0; i < 65536; i++) begin mem_arr[i] = '0; ref_mem[i] = '0; end

      // ---- reset state ----
      #2 reset_n = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset.gnt", {ld_gnt, d_gnt, f_gnt}, 0);
      chk("reset.rvalid", {ld_rvalid, d_rvalid, f_rvalid}, 0);
      chk("reset.rdata", rdata, 0);
      chk("reset.cpu_hold", cpu_hold, 0);
      chk("reset.mem", {mem_we, mem_addr, mem_din}, 0);
      @(negedge clk) reset_n = 1;

      // ---- loader write/read with lock, fetch blocked, lock release, stray ld_lock ----
      vt[0]  = mk(1, 1, 1, 16'h0003, 8'h5A, 0, 16'h0000, 3'b100, 3'b000, 8'h00, 1, 1);
      vt[1]  = mk(0, 1, 0, 16'h0003, 8'h00, 0, 16'h0000, 3'b000, 3'b000, 8'h00, 1, 0);
      vt[2]  = mk(1, 1, 0, 16'h0003, 8'h00, 0, 16'h0000, 3'b100, 3'b000, 8'h00, 1, 0);
      vt[3]  = mk(0, 1, 0, 16'h0003, 8'h00, 0, 16'h0000, 3'b000, 3'b000, 8'h00, 1, 0);
      vt[4]  = mk(0, 1, 0, 16'h0003, 8'h00, 1, 16'h0010, 3'b000, 3'b100, 8'h5A, 1, 0);
      for (int i = 5; i < 14; i++)
         vt[i] = mk(0, 1, 0, 16'h0003, 8'h00, 1, 16'h0010, 3'b000, 3'b000, 8'h5A, 1, 0);
      vt[14] = mk(0, 0, 0, 16'h0003, 8'h00, 1, 16'h0010, 3'b001, 3'b000, 8'h5A, 0, 0);
      vt[15] = mk(0, 0, 0, 16'h0003, 8'h00, 0, 16'h0010, 3'b000, 3'b000, 8'h5A, 0, 0);
      vt[16] = mk(0, 0, 0, 16'h0003, 8'h00, 0, 16'h0010, 3'b000, 3'b001, 8'h00, 0, 0);
      vt[17] = mk(0, 0, 0, 16'h0003, 8'h00, 0, 16'h0010, 3'b000, 3'b000, 8'h00, 0, 0);
      vt[18] = mk(0, 1, 0, 16'h0003, 8'h00, 1, 16'h0010, 3'b001, 3'b000, 8'h00, 0, 0);
      vt[19] = mk(0, 1, 0, 16'h0003, 8'h00, 0, 16'h0010, 3'b000, 3'b000, 8'h00, 0, 0);
      vt[20] = mk(0, 0, 0, 16'h0003, 8'h00, 0, 16'h0010, 3'b000, 3'b001, 8'h00, 0, 0);
      vt[21] = mk(0, 0, 0, 16'h0003, 8'h00, 0, 16'h0010, 3'b000, 3'b000, 8'h00, 0, 0);

      for (int i = 0; i < NV; i++) begin
         ld_req = vt[i].lr; ld_lock = vt[i].ll; ld_we = vt[i].lw;
         ld_addr = vt[i].la; ld_wdata = vt[i].lwd;
         f_req = vt[i].fr; f_addr = vt[i].fa; d_req = 0;
         tick();
         chk($sformatf("vec%0d.gnt", i), {ld_gnt, d_gnt, f_gnt}, vt[i].e_gnt);
         chk($sformatf("vec%0d.rvalid", i), {ld_rvalid, d_rvalid, f_rvalid}, vt[i].e_rv);
         chk($sformatf("vec%0d.rdata", i), rdata, vt[i].e_rdata);
         chk($sformatf("vec%0d.cpu_hold", i), cpu_hold, vt[i].e_hold);
         chk($sformatf("vec%0d.mem_we", i), mem_we, vt[i].e_we);
      end
      ld_lock = 0;

      // ---- data write then fetch read of the same address, back to back ----
      begin
         int dgc = -1, fgc = -1, rvc = -1, nwe = 0;
         d_req = 1; d_we = 1; d_addr = 16'h0002; d_wdata = 8'h04;
         f_req = 1; f_addr = 16'h0002;
         for (int k = 0; k < 12; k++) begin
            tick();
            if (mem_we) nwe++;
            if (d_gnt) begin
               dgc = k; d_req = 0; d_we = 0;
               chk("wr.mem_we", mem_we, 1);
               chk("wr.mem_addr", mem_addr, 16'h0002);
               chk("wr.mem_din", mem_din, 8'h04);
            end
            if (f_gnt) begin fgc = k; f_req = 0; end
            if (d_rvalid) chk("wr.no_d_rvalid", d_rvalid, 0);
            if (f_rvalid) begin rvc = k; chk("wr.f_rdata", rdata, 8'h04); end
         end
         d_req = 0; f_req = 0;
         chk("wr.d_first", 32'(dgc), 0);
         chk("wr.f_after", 32'(fgc), 32'(dgc + 2));
         chk("wr.f_latency", 32'(rvc), 32'(fgc + 2));
         chk("wr.we_cycles", 32'(nwe), 1);
      end

      ld_write(16'h0010, 8'h33);

      // ---- sustained data/fetch contention ----
      begin
         int ng = 0, nrv = 0, drain = 0;
         logic [1:0] eg;
         d_req = 1; d_we = 0; d_addr = 16'h0002;
         f_req = 1; f_addr = 16'h0010;
         for (int k = 0; k < 44 && drain <= 4; k++) begin
            tick();
            if (d_gnt || f_gnt) begin
`ifdef MEM_ARB_RR_EN
               eg = (ng % 2 == 0) ? 2'b10 : 2'b01;
`else
               eg = 2'b10;
`endif
               if (ng < 8) chk($sformatf("arb.grant%0d", ng), {d_gnt, f_gnt}, eg);
               ng++;
               if (ng == 8) begin d_req = 0; f_req = 0; end
            end
            if (d_rvalid) begin nrv++; chk("arb.d_rdata", rdata, 8'h04); end
            if (f_rvalid) begin nrv++; chk("arb.f_rdata", rdata, 8'h33); end
            if (ng >= 8) drain++;
         end
         d_req = 0; f_req = 0;
         chk("arb.grants", 32'(ng), 8);
         chk("arb.rvalids", 32'(nrv), 8);
      end

      // ---- reset during RESP of a pending loader read ----
      begin
         bit got = 0;
         ld_req = 1; ld_we = 0; ld_addr = 16'h0003; ld_lock = 0;
         for (int k = 0; k < 10 && !got; k++) begin
            tick();
            if (ld_gnt) got = 1;
         end
         ld_req = 0;
         chk("rst.pre_gnt", 32'(got), 1);
         tick();
         #2 reset_n = 0;
         #1;
         chk("rst.gnt", {ld_gnt, d_gnt, f_gnt}, 0);
         chk("rst.rvalid", {ld_rvalid, d_rvalid, f_rvalid}, 0);
         chk("rst.rdata", rdata, 0);
         chk("rst.cpu_hold", cpu_hold, 0);
         chk("rst.mem", {mem_we, mem_addr, mem_din}, 0);
         repeat (2) @(posedge clk);
         @(negedge clk) reset_n = 1;
         for (int k = 0; k < 5; k++) begin
            tick();
            chk("rst.no_rvalid", {ld_rvalid, d_rvalid, f_rvalid}, 0);
         end
         f_req = 1; f_addr = 16'h0010;
         tick();
         chk("rst.f_gnt", f_gnt, 1);
         f_req = 0;
         tick();
         chk("rst.f_rvalid_early", f_rvalid, 0);
         tick();
         chk("rst.f_rvalid", f_rvalid, 1);
         chk("rst.f_rdata", rdata, 8'h33);
      end

      // ---- random traffic against a transaction-level scoreboard ----
      begin
         logic          s_ld, s_ldwe, s_d, s_dwe, s_f;
         logic [AW-1:0] s_lda, s_da, s_fa, ga;
         logic [DW-1:0] s_ldd, s_dd, gd, p0_dat, p1_dat, edat;
         logic [2:0]    eg, erv, p0, p1;
         logic          gwe;
         bit            prev_g = 0, prev_ld = 0, last_d = 0;
         p0 = 0; p1 = 0; p0_dat = 0; p1_dat = 0;
         ld_req = 0; d_req = 0; f_req = 0; ld_lock = 0;
         s_ld = 0; s_ldwe = 0; s_d = 0; s_dwe = 0; s_f = 0;
         s_lda = 0; s_da = 0; s_fa = 0; s_ldd = 0; s_dd = 0;
         for (int c = 0; c < 800; c++) begin
            tick();
            eg = 3'b000;
            if (!prev_g) begin
               if (s_ld) eg = 3'b100;
`ifdef MEM_ARB_RR_EN
               else if (s_d && s_f) eg = last_d ? 3'b001 : 3'b010;
`endif
               else if (s_d) eg = 3'b010;
               else if (s_f) eg = 3'b001;
            end
            chk("rnd.gnt", {ld_gnt, d_gnt, f_gnt}, eg);
            erv = p1; edat = p1_dat; p1 = p0; p1_dat = p0_dat; p0 = 0;
            chk("rnd.rvalid", {ld_rvalid, d_rvalid, f_rvalid}, erv);
            if (erv != 0) chk("rnd.rdata", rdata, edat);
            gwe = 0; ga = 0; gd = 0;
            if (eg == 3'b100) begin gwe = s_ldwe; ga = s_lda; gd = s_ldd; end
            else if (eg == 3'b010) begin gwe = s_dwe; ga = s_da; gd = s_dd; end
            else if (eg == 3'b001) begin ga = s_fa; end
            if (eg != 0) begin
               chk("rnd.mem_addr", mem_addr, ga);
               if (gwe) begin
                  chk("rnd.mem_din", mem_din, gd);
                  ref_mem[ga] = gd;
               end else begin
                  p0 = eg; p0_dat = ref_mem[ga];
               end
               if (eg != 3'b100) last_d = (eg == 3'b010);
            end
            chk("rnd.mem_we", mem_we, gwe);
            chk("rnd.cpu_hold", cpu_hold, 32'((eg == 3'b100) || prev_ld));
            prev_g = (eg != 0); prev_ld = (eg == 3'b100);

            if (eg == 3'b100 || !ld_req) begin
               ld_req = ($urandom_range(0, 5) == 0); ld_we = $urandom_range(0, 1) != 0;
               ld_addr = raddr(); ld_wdata = DW'($urandom);
            end
            if (eg == 3'b010 || !d_req) begin
               d_req = ($urandom_range(0, 2) == 0); d_we = $urandom_range(0, 1) != 0;
               d_addr = raddr(); d_wdata = DW'($urandom);
            end
            if (eg == 3'b001 || !f_req) begin
               f_req = ($urandom_range(0, 2) == 0); f_addr = raddr();
            end
            s_ld = ld_req; s_ldwe = ld_we; s_lda = ld_addr; s_ldd = ld_wdata;
            s_d = d_req; s_dwe = d_we; s_da = d_addr; s_dd = d_wdata;
            s_f = f_req; s_fa = f_addr;
         end
         ld_req = 0; d_req = 0; f_req = 0;
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-owner controller for the shared single-port `mem` block.
- Arbitrates three requesters:
  - loader port: external fill/dump, used while the core is held;
  - fetch port: fetcher instruction/operand reads;
  - data port: decoder-driven loads/stores.
- Replaces the ad-hoc address/we/din muxing around `mem`.
- Sequences each access through a registered issue/response pipeline and returns read data with a per-port valid pulse.

Parameters:
- ADDR_WIDTH, 16, width of all address ports.
- DATA_WIDTH, 8, width of all data ports.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ld_req  in  1  loader access request.
- ld_lock  in  1  loader keeps ownership of mem after its grant.
- ld_we  in  1  loader write (1) / read (0).
- ld_addr  in  ADDR_WIDTH  loader address.
- ld_wdata  in  DATA_WIDTH  loader write data.
- ld_gnt  out  1  loader grant pulse.
- ld_rvalid  out  1  loader read data valid pulse.
- f_req  in  1  fetch read request.
- f_addr  in  ADDR_WIDTH  fetch address.
- f_gnt  out  1  fetch grant pulse.
- f_rvalid  out  1  fetch read data valid pulse.
- d_req  in  1  data access request.
- d_we  in  1  data write (1) / read (0).
- d_addr  in  ADDR_WIDTH  data address.
- d_wdata  in  DATA_WIDTH  data write data.
- d_gnt  out  1  data grant pulse.
- d_rvalid  out  1  data read data valid pulse.
- rdata  out  DATA_WIDTH  registered read data, shared by all ports.
- cpu_hold  out  1  fetch/data ports are blocked; core must stall.
- mem_we  out  1  to mem we.
- mem_addr  out  ADDR_WIDTH  to mem addr.
- mem_din  out  DATA_WIDTH  to mem din.
- mem_dout  in  DATA_WIDTH  from mem dout; synchronous read, valid the cycle after the address is presented.

Behaviour:
- Reset (asynchronous, reset_n low):
  - FSM goes to IDLE; lock_active, last_cpu and the pending-valid flags are cleared.
  - Every output is 0: all gnt, all rvalid, rdata, mem_we, mem_addr, mem_din, cpu_hold.
  - Any in-flight access is aborted and no rvalid is produced for it. mem_we drops immediately, without waiting for clk.
- FSM states: IDLE, ACCESS, RESP.
- Arbitration happens in IDLE and in RESP:
  - It samples req, we, addr and wdata of the winner at the rising edge.
  - On that edge the FSM goes to ACCESS and mem_addr/mem_we/mem_din are registered from the winner.
  - If nothing eligible is requesting, RESP goes to IDLE.
- ACCESS (1 cycle):
  - The winner's gnt is high for exactly this cycle.
  - mem performs the access at the edge ending ACCESS.
  - Next state is RESP; mem_we returns to 0 on that edge.
- RESP (1 cycle):
  - For a read, mem_dout is captured into rdata at the edge ending RESP.
  - The owner's rvalid pulses for the following cycle. That cycle overlaps the next IDLE or ACCESS.
  - Writes produce no rvalid.
- Latency and throughput:
  - Read: req sampled at edge N → gnt in cycle N+1 → rvalid and rdata in cycle N+3.
  - Back-to-back sustained rate: one access per 2 cycles.
- Requester rules:
  - Hold req/we/addr/wdata stable until gnt is seen.
  - Deassert req or change addr in the gnt cycle to avoid a repeat access.
  - rdata holds its value until the next read capture.
- Priority: loader > data > fetch (fixed).
- Lock behaviour:
  - If the loader is granted with ld_lock=1, lock_active sets on the ACCESS edge.
  - While lock_active, only the loader is eligible and cpu_hold=1.
  - lock_active clears at the first arbitration point where ld_lock=0.
  - cpu_hold falls together with lock_active.
- cpu_hold is also 1 whenever the current owner in ACCESS/RESP is the loader.
- Simultaneous events:
  - If all three requesters are active, the loader wins; the others wait with no grant.
  - A request arriving during ACCESS is first considered at the RESP edge.
- Address width is passed through unchanged; no wrap or range check.
- A request with ld_lock=1 and ld_req=0 has no effect.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined:
  - The loader remains highest priority.
  - Data and fetch alternate via the last_cpu flop, with data preferred after reset.
  - When both request, the one not served last wins; last_cpu updates on each CPU grant.
- Undefined: fixed priority data > fetch; last_cpu is not implemented.

Test Plan:
- Reset, then loader writes 0x5A to addr 0x0003 with ld_lock=1, then reads it back:
  - ld_gnt one cycle after each req;
  - ld_rvalid 3 cycles after the read req with rdata=0x5A;
  - cpu_hold=1 throughout.
- With lock held, f_req=1 at addr 0x0010 for 10 cycles:
  - no f_gnt;
  - after ld_lock=0 at an arbitration point, f_gnt follows and cpu_hold=0.
- f_req and d_req (read 0x0002) both continuously high, 8 grants, macro undefined:
  - all grants to data.
- Same stimulus, MEM_ARB_RR_EN defined:
  - grants alternate d,f,d,f…;
  - rvalid pairs carry the correct data for each address.
- d_req write 0x04 to 0x0002, then f_req read 0x0002 back-to-back:
  - f_rvalid returns 0x04;
  - mem_we high only in the write ACCESS cycle.
- reset_n low during RESP of a pending read:
  - all outputs 0 immediately;
  - no rvalid after release;
  - the next request is served normally.
